// File: rtl/accum_result_serializer.sv
// Serializes a 4x4x4 complex accumulator result set into eight 512-bit lines.
// Optional macro SERIALIZER_DOUBLE_BUFFER_EN adds a second ping-pong capture bank.
package accum_result_serializer_pkg;
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  typedef complex_t [0:3][0:3][0:3] set_t;
endpackage

module accum_result_serializer
  import accum_result_serializer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  complex_t [0:3][0:3][0:3]  in,
  input  logic                      in_valid,
  output logic [511:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_idx;
  logic       r_overrun;
  logic       w_hs;
  logic       w_done;
  logic       w_cap;
  logic       w_any_nx;
  set_t       w_rd_set;

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
  set_t       r_buf [2];
  logic [1:0] r_full;
  logic [1:0] w_full_nx;
  logic       r_rd;
  logic       w_rd_nx;
  logic       w_oth;
  logic       w_wr;
`else
  set_t       r_buf;
  logic       r_full;
  logic       w_full_nx;
`endif

  assign out_valid = (r_state == DRAIN);
  assign busy      = (r_state == DRAIN);
  assign out_idx   = r_idx;
  assign out_last  = out_valid && (r_idx == 3'd7);
  assign overrun   = r_overrun;

  assign w_hs   = out_valid && out_ready;
  assign w_done = w_hs && (r_idx == 3'd7);

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
  assign w_oth    = ~r_rd;
  assign w_rd_set = r_buf[r_rd];
  assign w_any_nx = |w_full_nx;

  // Pick a capture bank; the read bank is always the oldest full one.
  always_comb begin
    w_wr  = r_rd;
    w_cap = 1'b0;
    if (!r_full[r_rd]) begin
      w_wr  = r_rd;
      w_cap = in_valid;
    end else if (!r_full[w_oth]) begin
      w_wr  = w_oth;
      w_cap = in_valid;
    end else begin
      w_wr  = r_rd;
      w_cap = in_valid && w_done;
    end
    w_full_nx = r_full;
    if (w_done) begin
      w_full_nx[r_rd] = 1'b0;
    end
    if (w_cap) begin
      w_full_nx[w_wr] = 1'b1;
    end
    w_rd_nx = r_rd;
    if (w_done && w_full_nx[w_oth]) begin
      w_rd_nx = w_oth;
    end
  end

  // Bank storage, occupancy and read pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_full   <= '0;
      r_rd     <= 1'b0;
    end else begin
      if (w_cap) begin
        r_buf[w_wr] <= in;
      end
      r_full <= w_full_nx;
      r_rd   <= w_rd_nx;
    end
  end
`else
  assign w_rd_set = r_buf;
  assign w_any_nx = w_full_nx;

  // A line-7 handshake frees the only bank in the same cycle.
  always_comb begin
    w_cap     = in_valid && (!r_full || w_done);
    w_full_nx = r_full;
    if (w_done) begin
      w_full_nx = 1'b0;
    end
    if (w_cap) begin
      w_full_nx = 1'b1;
    end
  end

  // Single bank storage and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf  <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_cap) begin
        r_buf <= in;
      end
      r_full <= w_full_nx;
    end
  end
`endif

  // Next-state: leave DRAIN only once nothing remains queued.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_cap) begin
          w_state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (w_done && !w_any_nx) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State, line index and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= 3'd0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_hs) begin
        r_idx <= r_idx + 3'd1;
      end
      if (in_valid && !w_cap) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Line k: tile k/2, rows 2*(k%2) and +1, element n at bits 64n.
  for (genvar n = 0; n < 8; n++) begin : g_elem
    localparam logic [2:0] N = 3'(n);
    assign out_data[64*n +: 64] =
      w_rd_set[r_idx[2:1]][{r_idx[0], N[2]}][N[1:0]];
  end

endmodule

// File: tb/tb_accum_result_serializer.sv
// Randomized bench for accum_result_serializer with a queue-based model.
// Bank count follows SERIALIZER_DOUBLE_BUFFER_EN.
module tb_accum_result_serializer;
  import accum_result_serializer_pkg::*;

  typedef complex_t [0:63] flat_t;

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  set_t         din = '0;
  logic         in_valid = 1'b0;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         overrun;

  int n_chk = 0;
  int n_pass = 0;

  flat_t      m_q[$];
  logic [2:0] m_idx = 3'd0;
  logic       m_ovr = 1'b0;

  accum_result_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic flat_t rnd_set();
    flat_t f;
    for (int i = 0; i < 64; i++) f[i] = {$urandom, $urandom};
    return f;
  endfunction

  function automatic flat_t ramp_set();
    flat_t f;
    for (int i = 0; i < 64; i++) f[i] = {32'(i), 32'd0};
    return f;
  endfunction

  function automatic set_t to_set(input flat_t f);
    set_t s;
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[t][r][c] = f[t*16 + r*4 + c];
    return s;
  endfunction

  function automatic logic [511:0] line_of(input flat_t f, input int k);
    logic [511:0] l;
    for (int n = 0; n < 8; n++)
      l[64*n +: 64] = f[(k/2)*16 + (2*(k%2) + n/4)*4 + n%4];
    return l;
  endfunction

  task automatic step(input logic iv, input logic rdy, input flat_t f);
    logic hs, done, acc;
    int   held;
    @(negedge clk);
    in_valid  = iv;
    out_ready = rdy;
    din       = to_set(f);
    #1;
    chk("out_valid", 512'(out_valid), 512'(m_q.size() != 0));
    chk("busy", 512'(busy), 512'(m_q.size() != 0));
    chk("overrun", 512'(overrun), 512'(m_ovr));
    if (m_q.size() != 0) begin
      chk("out_idx", 512'(out_idx), 512'(m_idx));
      chk("out_last", 512'(out_last), 512'(m_idx == 3'd7));
      chk("out_data", out_data, line_of(m_q[0], int'(m_idx)));
    end else begin
      chk("out_last_idle", 512'(out_last), 512'(0));
    end
    hs   = (m_q.size() != 0) && rdy;
    done = hs && (m_idx == 3'd7);
    held = m_q.size() - (done ? 1 : 0);
    acc  = iv && (held < NBANK);
    if (hs) m_idx = m_idx + 3'd1;
    if (done) void'(m_q.pop_front());
    if (acc) m_q.push_back(f);
    if (iv && !acc) m_ovr = 1'b1;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_overrun", 512'(overrun), 512'(0));
    chk("rst_idx", 512'(out_idx), 512'(0));
    chk("rst_last", 512'(out_last), 512'(0));
    chk("rst_data", out_data, 512'(0));
    m_q.delete();
    m_idx = 3'd0;
    m_ovr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic fired;
    do_reset();

    // Ramp set, always ready.
    step(1'b1, 1'b1, ramp_set());
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rnd_set());

    // Ramp set, ready toggling.
    step(1'b1, 1'b0, ramp_set());
    for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), rnd_set());

    // New set coincident with line-7 handshake.
    step(1'b1, 1'b1, rnd_set());
    fired = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!fired && m_q.size() == 1 && m_idx == 3'd7) begin
        fired = 1'b1;
        step(1'b1, 1'b1, rnd_set());
      end else begin
        step(1'b0, 1'b1, rnd_set());
      end
    end
    chk("coincide_fired", 512'(fired), 512'(1));

    // Second set arrives at line 3.
    step(1'b1, 1'b1, rnd_set());
    fired = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!fired && m_idx == 3'd3) begin
        fired = 1'b1;
        step(1'b1, 1'b1, rnd_set());
      end else begin
        step(1'b0, 1'b1, rnd_set());
      end
    end
    chk("line3_ovr", 512'(overrun), 512'(NBANK == 1));
    do_reset();

    // Reset at line 4, then idle.
    step(1'b1, 1'b1, rnd_set());
    for (int i = 0; i < 12 && m_idx != 3'd4; i++)
      step(1'b0, 1'b1, rnd_set());
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rnd_set());

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           rnd_set());
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
